// File: rtl/ldpc_iter_ctrl.sv
// Iteration scheduler for the LDPC decoder array: LLR load, CNU/VNU phases,
// syndrome check and termination on convergence, iteration limit or abort.
module ldpc_iter_ctrl #(
    parameter int ITER_W  = 8,
    parameter int CNU_CYC = 1,
    parameter int VNU_CYC = 1,
    parameter int PH_W    = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ITER_W-1:0] max_iter_i,
    input  logic              syndrome_ok_i,
    output logic              llr_load_o,
    output logic              cnu_en_o,
    output logic              vnu_en_o,
    output logic              chk_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o,
    output logic [ITER_W-1:0] iter_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CNU,
        S_VNU,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [PH_W-1:0] CNU_LAST = PH_W'(CNU_CYC - 1);
    localparam logic [PH_W-1:0] VNU_LAST = PH_W'(VNU_CYC - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [ITER_W-1:0] lim_q, lim_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              conv_q, conv_d;

    // One extra bit so the limit compare cannot alias when lim is all-ones.
    logic [ITER_W:0]   iter_inc;
    logic              last_iter;

    assign iter_inc  = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
    assign last_iter = (iter_inc == {1'b0, lim_q});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            lim_q   <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            lim_q   <= lim_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        lim_d   = lim_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        // Abort outranks every other transition, including a passing CHECK.
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            ph_d    = '0;
            conv_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_LOAD;
                        ph_d    = '0;
                        lim_d   = (max_iter_i == '0) ? ITER_W'(1) : max_iter_i;
                        iter_d  = '0;
                        conv_d  = 1'b0;
                    end
                end
                S_LOAD: begin
                    state_d = S_CNU;
                    ph_d    = '0;
                end
                S_CNU: begin
                    if (ph_q == CNU_LAST) begin
                        state_d = S_VNU;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_VNU: begin
                    if (ph_q == VNU_LAST) begin
                        state_d = S_CHECK;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_CHECK: begin
                    iter_d = iter_inc[ITER_W-1:0];
                    if (syndrome_ok_i) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                    end else if (last_iter) begin
                        state_d = S_DONE;
                        conv_d  = 1'b0;
                    end else begin
                        state_d = S_CNU;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        llr_load_o = 1'b0;
        cnu_en_o   = 1'b0;
        vnu_en_o   = 1'b0;
        chk_en_o   = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != S_IDLE);
        unique case (state_q)
            S_LOAD:  llr_load_o = 1'b1;
            S_CNU:   cnu_en_o   = 1'b1;
            S_VNU:   vnu_en_o   = 1'b1;
            S_CHECK: chk_en_o   = 1'b1;
            S_DONE:  done_o     = 1'b1;
            default: ;
        endcase
    end

    assign converged_o  = conv_q;
    assign iter_count_o = iter_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Bench for ldpc_iter_ctrl: two instances (1/1 and 3/2 phase lengths) share the
// stimulus and are compared every cycle against a frame-relative cycle model.
module tb_ldpc_iter_ctrl;

    logic       clk = 1'b0;
    logic       reset_i, start_i, abort_i, syn_i;
    logic [7:0] max_iter_i;

    logic       llr[2], cnu[2], vnu[2], chk[2], busy[2], done[2], conv[2];
    logic [7:0] iter[2];

    always #5 clk = ~clk;

    ldpc_iter_ctrl #(.ITER_W(8), .CNU_CYC(1), .VNU_CYC(1), .PH_W(4)) u_def (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .max_iter_i(max_iter_i), .syndrome_ok_i(syn_i),
        .llr_load_o(llr[0]), .cnu_en_o(cnu[0]), .vnu_en_o(vnu[0]), .chk_en_o(chk[0]),
        .busy_o(busy[0]), .done_o(done[0]), .converged_o(conv[0]), .iter_count_o(iter[0])
    );

    ldpc_iter_ctrl #(.ITER_W(8), .CNU_CYC(3), .VNU_CYC(2), .PH_W(4)) u_mc (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .max_iter_i(max_iter_i), .syndrome_ok_i(syn_i),
        .llr_load_o(llr[1]), .cnu_en_o(cnu[1]), .vnu_en_o(vnu[1]), .chk_en_o(chk[1]),
        .busy_o(busy[1]), .done_o(done[1]), .converged_o(conv[1]), .iter_count_o(iter[1])
    );

    int checks = 0;
    int failures = 0;

    // Stimulus knobs, keyed on the cycle number relative to the accepted start.
    int rel;
    int start_at, start_at2, abort_at, reset_at, chg_at, chg_val;
    int syn_mode, syn_at, syn_const, syn_pct;

    // Reference model state per instance.
    int m_act[2], m_c[2], m_lim[2], m_iter[2], m_conv[2], m_done_c[2];
    int done_at[2];
    logic prev_done[2] = '{1'b0, 1'b0};
    string nm[2] = '{"def", "mc"};

    function automatic int cc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int vc(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame model: cycle 1 is LOAD, then iterations of T cycles (CNU, VNU, CHECK),
    // and DONE one cycle after the terminating CHECK.
    task automatic model_step(input int k);
        int t;
        t = cc(k) + vc(k) + 1;
        if (reset_i) begin
            m_act[k] = 0; m_conv[k] = 0; m_iter[k] = 0;
        end else if (m_act[k] == 0) begin
            if (start_i) begin
                m_act[k] = 1; m_c[k] = 1; m_iter[k] = 0; m_conv[k] = 0; m_done_c[k] = 0;
                m_lim[k] = (max_iter_i == 8'd0) ? 1 : int'(max_iter_i);
            end
        end else if (abort_i) begin
            m_act[k] = 0; m_conv[k] = 0;
        end else if (m_done_c[k] != 0 && m_c[k] == m_done_c[k]) begin
            m_act[k] = 0;
        end else begin
            if (m_c[k] >= 2 && (m_c[k] - 2) % t == t - 1) begin
                m_iter[k]++;
                if (syn_i) begin
                    m_conv[k] = 1; m_done_c[k] = m_c[k] + 1;
                end else if (m_iter[k] == m_lim[k]) begin
                    m_conv[k] = 0; m_done_c[k] = m_c[k] + 1;
                end
            end
            m_c[k]++;
        end
    endtask

    task automatic compare(input int k);
        int t, ph, is_done;
        logic [3:0] e_en;
        t = cc(k) + vc(k) + 1;
        is_done = (m_act[k] != 0 && m_done_c[k] != 0 && m_c[k] == m_done_c[k]) ? 1 : 0;
        ph = (m_act[k] != 0 && m_c[k] >= 2 && is_done == 0) ? (m_c[k] - 2) % t : -1;
        e_en[3] = (m_act[k] != 0 && m_c[k] == 1);
        e_en[2] = (ph >= 0 && ph < cc(k));
        e_en[1] = (ph >= cc(k) && ph < cc(k) + vc(k));
        e_en[0] = (ph == cc(k) + vc(k));
        check({"enables_", nm[k]}, 32'({llr[k], cnu[k], vnu[k], chk[k]}), 32'(e_en));
        check({"busy_", nm[k]}, 32'(busy[k]), 32'(m_act[k] != 0));
        check({"done_", nm[k]}, 32'(done[k]), 32'(is_done));
        check({"converged_", nm[k]}, 32'(conv[k]), 32'(m_conv[k]));
        check({"iter_count_", nm[k]}, 32'(iter[k]), 32'(m_iter[k]));
        check({"onehot_", nm[k]}, 32'($onehot0({llr[k], cnu[k], vnu[k], chk[k]})), 32'(1));
        check({"done_width_", nm[k]}, 32'(prev_done[k] & done[k]), 32'(0));
        prev_done[k] = done[k];
        if (done[k] === 1'b1 && done_at[k] == 0) done_at[k] = rel;
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        rel++;
        for (int k = 0; k < 2; k++) compare(k);
        start_i = (rel == start_at) || (rel == start_at2);
        abort_i = (rel == abort_at);
        reset_i = (rel == reset_at);
        if (rel == chg_at) max_iter_i = 8'(chg_val);
        case (syn_mode)
            0:       syn_i = (syn_const != 0);
            1:       syn_i = (rel == syn_at);
            default: syn_i = ($urandom_range(99) < 32'(syn_pct));
        endcase
    endtask

    task automatic begin_frame(input int mi, input int mode, input int s);
        start_at = -1; start_at2 = -1; abort_at = -1; reset_at = -1;
        chg_at = -1; chg_val = 0; syn_at = -1; syn_pct = 0;
        syn_mode = mode; syn_const = s;
        max_iter_i = 8'(mi);
        syn_i = (mode == 0) && (s != 0);
        abort_i = 1'b0; reset_i = 1'b0;
        start_i = 1'b1;
        rel = 0;
        done_at[0] = 0; done_at[1] = 0;
    endtask

    task automatic run_to(input int r);
        while (rel < r) tick();
    endtask

    task automatic run_frame(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((m_act[0] != 0 || m_act[1] != 0 || busy[0] === 1'b1 || busy[1] === 1'b1)
                   && n < budget);
        check("frame_timeout", 32'(n < budget), 32'(1));
    endtask

    initial begin
        // Reset state
        begin_frame(0, 0, 0);
        start_i = 1'b0; reset_i = 1'b1; reset_at = 1;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_c[k] = 0; m_lim[k] = 1; m_iter[k] = 0; m_conv[k] = 0; m_done_c[k] = 0;
        end
        tick(); tick(); tick();
        check("reset_iter", 32'(iter[0]), 32'(0));
        check("reset_busy", 32'(busy[0]), 32'(0));

        // Early convergence
        begin_frame(10, 0, 1);
        run_frame(100);
        check("early_done_cycle", 32'(done_at[0]), 32'(5));
        check("early_converged", 32'(conv[0]), 32'(1));
        check("early_iter", 32'(iter[0]), 32'(1));
        check("early_done_cycle_mc", 32'(done_at[1]), 32'(8));

        // Iteration limit
        begin_frame(3, 0, 0);
        run_frame(100);
        check("limit_done_cycle", 32'(done_at[0]), 32'(11));
        check("limit_converged", 32'(conv[0]), 32'(0));
        check("limit_iter", 32'(iter[0]), 32'(3));
        check("limit_done_cycle_mc", 32'(done_at[1]), 32'(20));
        check("limit_iter_mc", 32'(iter[1]), 32'(3));

        // max_iter of zero runs one iteration
        begin_frame(0, 0, 0);
        run_frame(100);
        check("zero_lim_done_cycle", 32'(done_at[0]), 32'(5));
        check("zero_lim_iter", 32'(iter[0]), 32'(1));
        check("zero_lim_iter_mc", 32'(iter[1]), 32'(1));

        // Multi-cycle phases converging in the second CHECK (cycle 13)
        begin_frame(10, 1, 0);
        syn_at = 13;
        run_frame(100);
        check("multi_done_cycle", 32'(done_at[1]), 32'(14));
        check("multi_iter", 32'(iter[1]), 32'(2));
        check("multi_converged", 32'(conv[1]), 32'(1));

        // Abort in the VNU cycle of iteration 2
        begin_frame(5, 0, 0);
        abort_at = 6;
        run_frame(100);
        check("abort_no_done", 32'(done_at[0]), 32'(0));
        check("abort_iter", 32'(iter[0]), 32'(1));
        check("abort_converged", 32'(conv[0]), 32'(0));
        check("abort_idle_cycle", 32'(rel), 32'(7));

        // Abort together with a passing CHECK
        begin_frame(5, 0, 1);
        abort_at = 4;
        run_frame(100);
        check("abort_chk_no_done", 32'(done_at[0]), 32'(0));
        check("abort_chk_converged", 32'(conv[0]), 32'(0));
        check("abort_chk_iter", 32'(iter[0]), 32'(0));

        // Start and max_iter changes while busy are ignored
        begin_frame(2, 0, 0);
        start_at = 2; chg_at = 2; chg_val = 7;
        run_frame(200);
        check("busy_start_done_cycle", 32'(done_at[0]), 32'(8));
        check("busy_start_iter", 32'(iter[0]), 32'(2));

        // Back-to-back frame: start in the first IDLE cycle after DONE
        begin_frame(3, 1, 0);
        syn_at = 7; start_at2 = 9;
        run_to(8);
        check("b2b_first_converged", 32'(conv[0]), 32'(1));
        run_to(10);
        check("b2b_load", 32'(llr[0]), 32'(1));
        check("b2b_iter_cleared", 32'(iter[0]), 32'(0));
        check("b2b_conv_cleared", 32'(conv[0]), 32'(0));
        run_frame(200);
        check("b2b_second_iter", 32'(iter[0]), 32'(3));

        // Reset during a passing CHECK
        begin_frame(5, 1, 0);
        syn_at = 7; reset_at = 7;
        run_to(8);
        check("rst_chk_busy", 32'(busy[0]), 32'(0));
        check("rst_chk_iter", 32'(iter[0]), 32'(0));
        check("rst_chk_converged", 32'(conv[0]), 32'(0));
        check("rst_chk_done", 32'(done[0]), 32'(0));
        run_frame(100);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            begin_frame(int'($urandom_range(0, 6)), 2, 0);
            syn_pct = int'($urandom_range(10, 60));
            if ($urandom_range(3) == 0) abort_at = int'($urandom_range(1, 25));
            if ($urandom_range(3) == 0) start_at = int'($urandom_range(1, 12));
            if ($urandom_range(3) == 0) begin
                chg_at = int'($urandom_range(1, 10));
                chg_val = int'($urandom_range(0, 6));
            end
            if ($urandom_range(7) == 0) reset_at = int'($urandom_range(2, 20));
            run_frame(400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
